jt51_wrseq: RTL

- Host-side write sequencer that sits in front of the YM2151 register interface (`write`/`a0`/`din`/`busy`).
- Queues (register address, data) pairs from a host or a replay engine in a small FIFO.
- Replays each pair as an address strobe followed by a data strobe, then holds off until the register interface's `busy` clears.
- Frees software from polling `busy`, and guarantees each strobe presents a clean rising edge of `write`.

---
 rtl/jt51_wrseq_pkg.sv | 28 ++
 rtl/jt51_wrseq_fifo.sv | 57 +++++
 rtl/jt51_wrseq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jt51_wrseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt51_wrseq_pkg
// Purpose  : Shared constants for the YM2151 write sequencer: FSM state
//            encoding and the FIFO entry layout {addr, data}.
// Revision : 1.0 - initial release
// ============================================================================
package jt51_wrseq_pkg;

    // One queued register write: address in [15:8], data in [7:0]
    localparam int c_ENTRY_W = 16;

    typedef logic [2:0] wrseq_state_t;

    localparam wrseq_state_t ST_IDLE  = 3'd0;
    localparam wrseq_state_t ST_ADDR  = 3'd1;
    localparam wrseq_state_t ST_GAPW  = 3'd2;
    localparam wrseq_state_t ST_DATA  = 3'd3;
    localparam wrseq_state_t ST_ARM   = 3'd4;
    localparam wrseq_state_t ST_WAITB = 3'd5;

    function automatic logic [c_ENTRY_W-1:0] pack_entry(input logic [7:0] addr,
                                                        input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_wrseq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jt51_wrseq_fifo
// Purpose  : Single-clock FIFO of 2**AW {addr,data} entries with a
//            synchronous flush; the head entry is always visible on dout.
// Revision : 1.0 - initial release
// ============================================================================
module jt51_wrseq_fifo
    import jt51_wrseq_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [c_ENTRY_W-1:0] din,
    output logic [c_ENTRY_W-1:0] dout,
    output logic [AW:0]          level
);

    logic [c_ENTRY_W-1:0] r_mem [2**AW];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;

    // Storage array: written on accepted pushes only, never reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)      r_level <= r_level + 1'b1;
            else if (!push && pop) r_level <= r_level - 1'b1;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/jt51_wrseq.sv
`default_nettype none
// ============================================================================
// Module   : jt51_wrseq
// Purpose  : Host-side write sequencer for the YM2151 register interface.
//            Queues {addr,data} pairs and replays each as an address strobe,
//            GAP idle cycles, a data strobe, then waits for busy to clear.
//            Optional macro JT51_WRSEQ_ADDRSKIP_EN skips the address strobe
//            when the head address repeats the last one strobed.
// Revision : 1.0 - initial release
// ============================================================================
module jt51_wrseq
    import jt51_wrseq_pkg::*;
#(
    parameter int AW  = 3,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_addr,
    input  logic [7:0]    in_data,
    input  logic          flush,
    output logic          write,
    output logic          a0,
    output logic [7:0]    dout,
    input  logic          busy,
    output logic [AW:0]   level,
    output logic          idle
);

    localparam logic [AW:0] c_DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [2:0]  c_GAP_LAST = 3'(GAP - 1);

    wrseq_state_t         r_state, w_state_nxt;
    logic [2:0]           r_gap_cnt, w_gap_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_write, w_write_nxt;
    logic                 r_a0, w_a0_nxt;
    logic [7:0]           r_dout, w_dout_nxt;
    logic                 w_push, w_pop, w_skip;
    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_unused_cen;

    // cen only matters to the timeout variant; kept on the port for pin compatibility
    assign w_unused_cen = cen;

    assign in_ready = (level != c_DEPTH);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = (r_state == ST_DATA);

    jt51_wrseq_fifo #(
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .din   (pack_entry(in_addr, in_data)),
        .dout  (w_head),
        .level (level)
    );

`ifdef JT51_WRSEQ_ADDRSKIP_EN
    logic [7:0] r_last_addr;
    logic       r_last_vld;

    assign w_skip = r_last_vld && (w_head[15:8] == r_last_addr);

    // Remember the address of the last ADDR strobe; flush forgets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= 8'h00;
            r_last_vld  <= 1'b0;
        end else if (flush) begin
            r_last_vld  <= 1'b0;
        end else if (r_state == ST_IDLE && w_state_nxt == ST_ADDR) begin
            r_last_addr <= w_head[15:8];
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered one cycle later
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_data_nxt  = r_data;
        w_write_nxt = 1'b0;
        w_a0_nxt    = r_a0;
        w_dout_nxt  = r_dout;
        case (r_state)
            ST_IDLE: begin
                if (level != '0 && !busy) begin
                    w_data_nxt  = w_head[7:0];
                    w_write_nxt = 1'b1;
                    if (w_skip) begin
                        w_state_nxt = ST_DATA;
                        w_a0_nxt    = 1'b1;
                        w_dout_nxt  = w_head[7:0];
                    end else begin
                        w_state_nxt = ST_ADDR;
                        w_a0_nxt    = 1'b0;
                        w_dout_nxt  = w_head[15:8];
                    end
                end
            end
            ST_ADDR: begin
                w_state_nxt = ST_GAPW;
                w_gap_nxt   = c_GAP_LAST;
            end
            ST_GAPW: begin
                if (r_gap_cnt == 3'd0) begin
                    w_state_nxt = ST_DATA;
                    w_write_nxt = 1'b1;
                    w_a0_nxt    = 1'b1;
                    w_dout_nxt  = r_data;
                end else begin
                    w_gap_nxt   = r_gap_cnt - 3'd1;
                end
            end
            // The head is popped while in DATA; ARM absorbs busy's set latency
            ST_DATA:  w_state_nxt = ST_ARM;
            ST_ARM:   w_state_nxt = ST_WAITB;
            ST_WAITB: if (!busy) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_write_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 3'd0;
            r_data    <= 8'h00;
            r_write   <= 1'b0;
            r_a0      <= 1'b0;
            r_dout    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_data    <= w_data_nxt;
            r_write   <= w_write_nxt;
            r_a0      <= w_a0_nxt;
            r_dout    <= w_dout_nxt;
        end
    end

    assign write = r_write;
    assign a0    = r_a0;
    assign dout  = r_dout;
    assign idle  = (level == '0) && (r_state == ST_IDLE);

endmodule
`default_nettype wire
